// File: rtl/seg_pkg.sv
// Shared types, constants and the hex-to-segment table for the 7-segment scanner.
// Combinational constants only; no latency; no flow control.
// Segment order is {dp,g,f,e,d,c,b,a}, active-low throughout.
package seg_pkg;

    typedef logic [7:0] seg_t;

    typedef enum logic {PH_DEAD, PH_DRIVE} phase_t;

    localparam seg_t SEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a}; entry n is the glyph for nibble n (lowercase b and d).
    localparam logic [15:0][6:0] HEX7_TAB = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex7_decode.sv
// Hex nibble to active-low 7-segment pattern.
// Purely combinational, zero latency.
// No flow control.
module hex7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX7_TAB[nib];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 7-segment scanner with per-frame snapshot, dead-time and optional SEG_LZB_EN leading-zero blanking.
// AN/SEG registered, 1-clock latency after slot change; inputs captured at each frame boundary.
// No backpressure: free-running refresh from the board clock.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int CLK_DIV  = 2500,
    parameter int DEAD_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            SEG,
    output logic                  frame_done
);

    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int DEAD_EFF = (CLK_DIV == 1) ? 0 : DEAD_CYC;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [SW-1:0] SEL_MAX = SW'(DIGITS - 1);

    logic [DW-1:0]          div_cnt;
    logic [SW-1:0]          sel;
    logic                   first_tick;
    logic                   tick;
    logic                   boundary;
    logic [DIGITS-1:0][3:0] data_sh;
    logic [DIGITS-1:0]      dp_sh;
    logic [DIGITS-1:0]      blank_sh;
    logic [DIGITS-1:0]      lzb_mask;
    logic [DIGITS-1:0]      an_sel;
    logic [3:0]             nib;
    logic                   dp_cur;
    logic                   dark_cur;
    logic [6:0]             hex_seg;
    phase_t                 phase;

    assign tick     = (div_cnt == DIV_MAX);
    assign boundary = tick && (first_tick || (sel == SEL_MAX));

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt    <= '0;
            sel        <= '0;
            first_tick <= 1'b1;
            frame_done <= 1'b0;
            data_sh    <= '0;
            dp_sh      <= '0;
            blank_sh   <= '1;
        end else begin
            frame_done <= boundary;
            if (tick) begin
                div_cnt    <= '0;
                first_tick <= 1'b0;
                // The first tick after reset restarts the scan at slot 0.
                sel        <= boundary ? '0 : sel + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (boundary) begin
                data_sh  <= data;
                dp_sh    <= dp;
                blank_sh <= blank;
            end
        end
    end

    generate
        if (DEAD_EFF == 0) begin : g_no_dead
            assign phase = PH_DRIVE;
        end else begin : g_dead
            localparam logic [DW-1:0] DEAD_V = DW'(DEAD_EFF);
            assign phase = (div_cnt < DEAD_V) ? PH_DEAD : PH_DRIVE;
        end
    endgenerate

`ifdef SEG_LZB_EN
    // A digit goes dark while it and every digit above it is a plain zero; digit 0 always shows.
    logic lz_run;
    always_comb begin
        lz_run   = 1'b1;
        lzb_mask = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_run      = lz_run && (data_sh[i] == 4'h0) && !dp_sh[i];
            lzb_mask[i] = lz_run;
        end
    end
`else
    assign lzb_mask = '0;
`endif

    always_comb begin
        nib      = '0;
        dp_cur   = 1'b0;
        dark_cur = 1'b1;
        an_sel   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel == SW'(i)) begin
                nib       = data_sh[i];
                dp_cur    = dp_sh[i];
                dark_cur  = blank_sh[i] | lzb_mask[i];
                an_sel[i] = 1'b0;
            end
        end
    end

    hex7_decode u_hex7 (
        .nib (nib),
        .seg (hex_seg)
    );

    // Blanked digits keep their anode on so every slot has the same duty cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            AN  <= '1;
            SEG <= SEG_OFF;
        end else if (phase == PH_DEAD) begin
            AN  <= '1;
            SEG <= SEG_OFF;
        end else begin
            AN  <= an_sel;
            SEG <= dark_cur ? SEG_OFF : {~dp_cur, hex_seg};
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: 8-digit/4-clock slots plus a 1-digit/1-clock instance.
module tb_seg_scan_display;

    logic        clk;
    logic        rst;
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic [7:0]  AN;
    logic [7:0]  SEG;
    logic        frame_done;

    logic [3:0]  data1;
    logic        dp1;
    logic        blank1;
    logic        AN1;
    logic [7:0]  SEG1;
    logic        fd1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    exp_t sb[$];

    logic [31:0] sh_data;
    logic [7:0]  sh_dp;
    logic [7:0]  sh_blank;

    seg_scan_display #(.DIGITS(8), .CLK_DIV(4), .DEAD_CYC(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .dp         (dp),
        .blank      (blank),
        .AN         (AN),
        .SEG        (SEG),
        .frame_done (frame_done)
    );

    seg_scan_display #(.DIGITS(1), .CLK_DIV(1), .DEAD_CYC(0)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .data       (data1),
        .dp         (dp1),
        .blank      (blank1),
        .AN         (AN1),
        .SEG        (SEG1),
        .frame_done (fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hex7_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic lz_dark(input int i);
`ifdef SEG_LZB_EN
        if (i == 0) return 1'b0;
        for (int k = i; k < 8; k++)
            if (sh_data[4*k +: 4] != 4'h0 || sh_dp[k]) return 1'b0;
        return 1'b1;
`else
        return (i < 0);
`endif
    endfunction

    // Called at the negedge just after a frame_done edge; checks the whole next frame.
    task automatic frame_check(input int mid_j, input logic [31:0] nd,
                               input logic [7:0] ndp, input logic [7:0] nbl);
        exp_t e;
        exp_t got;
        for (int j = 0; j < 32; j++) begin
            int s;
            s = j / 4;
            if (j % 4 == 0) begin
                e.an  = 8'hFF;
                e.seg = 8'hFF;
            end else begin
                e.an  = ~(8'h01 << s);
                if (sh_blank[s] || lz_dark(s))
                    e.seg = 8'hFF;
                else
                    e.seg = {~sh_dp[s], hex7_ref(sh_data[4*s +: 4])};
            end
            e.fd = (j == 31);
            sb.push_back(e);
        end
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            e   = sb.pop_front();
            got = '{an: AN, seg: SEG, fd: frame_done};
            checks++;
            if (got.an !== e.an) begin
                errors++;
                $display("FAIL an slot%0d cyc%0d: got %h want %h", j / 4, j % 4, got.an, e.an);
            end
            checks++;
            if (got.seg !== e.seg) begin
                errors++;
                $display("FAIL seg slot%0d cyc%0d: got %h want %h", j / 4, j % 4, got.seg, e.seg);
            end
            checks++;
            if (got.fd !== e.fd) begin
                errors++;
                $display("FAIL frame_done cyc%0d: got %b want %b", j, got.fd, e.fd);
            end
            if (j == mid_j) begin
                data  = nd;
                dp    = ndp;
                blank = nbl;
            end
        end
        sh_data  = data;
        sh_dp    = dp;
        sh_blank = blank;
    endtask

    task automatic wait_first_frame(input string tag);
        int n;
        n = 0;
        while (n < 50 && frame_done !== 1'b1) begin
            @(negedge clk);
            n++;
            checks++;
            if (frame_done !== 1'b1 && SEG !== 8'hFF) begin
                errors++;
                $display("FAIL %s dark_before_frame: SEG %h want ff", tag, SEG);
            end
        end
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL %s first_frame_done: after %0d clocks want 4", tag, n);
        end
        sh_data  = data;
        sh_dp    = dp;
        sh_blank = blank;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        data   = 32'h1234ABCD;
        dp     = 8'h00;
        blank  = 8'h00;
        data1  = 4'h7;
        dp1    = 1'b1;
        blank1 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (AN !== 8'hFF) begin
                errors++;
                $display("FAIL reset_an: got %h want ff", AN);
            end
            checks++;
            if (SEG !== 8'hFF) begin
                errors++;
                $display("FAIL reset_seg: got %h want ff", SEG);
            end
            checks++;
            if (frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_fd: got %b want 0", frame_done);
            end
        end
        rst = 1'b1;
        wait_first_frame("reset");
    endtask

    task automatic test_scan();
        frame_check(-1, 32'h0, 8'h0, 8'h0);
        frame_check(-1, 32'h0, 8'h0, 8'h0);
    endtask

    task automatic test_tear();
        frame_check(13, 32'hFFFFFFFF, 8'h00, 8'h00);
        frame_check(-1, 32'h0, 8'h0, 8'h0);
    endtask

    task automatic test_dp_blank();
        data  = 32'h1234ABCD;
        dp    = 8'h04;
        blank = 8'h80;
        frame_check(-1, 32'h0, 8'h0, 8'h0);
        frame_check(-1, 32'h0, 8'h0, 8'h0);
    endtask

    task automatic test_zero_patterns();
        logic [31:0] pd [3];
        logic [7:0]  pp [3];
        pd[0] = 32'h00000050; pp[0] = 8'h00;
        pd[1] = 32'h00000000; pp[1] = 8'h00;
        pd[2] = 32'h00000000; pp[2] = 8'h10;
        for (int p = 0; p < 3; p++) begin
            data  = pd[p];
            dp    = pp[p];
            blank = 8'h00;
            frame_check(-1, 32'h0, 8'h0, 8'h0);
            frame_check(-1, 32'h0, 8'h0, 8'h0);
        end
    endtask

    task automatic test_reset_mid();
        data = 32'h89ABCDEF;
        dp   = 8'h01;
        frame_check(-1, 32'h0, 8'h0, 8'h0);
        repeat (22) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (AN !== 8'hFF || SEG !== 8'hFF || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_dark: AN %h SEG %h fd %b want ff ff 0", AN, SEG, frame_done);
        end
        rst = 1'b1;
        wait_first_frame("midreset");
        frame_check(-1, 32'h0, 8'h0, 8'h0);
    endtask

    task automatic test_edge1();
        logic [7:0] exp_seg;
        exp_seg = {~dp1, hex7_ref(data1)};
        repeat (8) begin
            @(negedge clk);
            checks++;
            if (AN1 !== 1'b0 || fd1 !== 1'b1) begin
                errors++;
                $display("FAIL edge1_an_fd: AN %b fd %b want 0 1", AN1, fd1);
            end
            checks++;
            if (SEG1 !== exp_seg) begin
                errors++;
                $display("FAIL edge1_seg: got %h want %h", SEG1, exp_seg);
            end
        end
        data1 = 4'hA;
        dp1   = 1'b0;
        exp_seg = {1'b1, hex7_ref(4'hA)};
        repeat (2) @(negedge clk);
        checks++;
        if (SEG1 !== exp_seg) begin
            errors++;
            $display("FAIL edge1_update: got %h want %h", SEG1, exp_seg);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear();
        test_dp_blank();
        test_zero_patterns();
        test_reset_mid();
        test_edge1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
